// File: rtl/lt24_touch_emu_pkg.sv
// Shared types and constants for the LT24 touch controller emulator:
// FSM states, Avalon register map, ADC channel codes and command-byte fields.
package lt24_touch_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_CMD,
    ST_CONV,
    ST_DATA
  } emu_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_XY     = 2'd1;
  localparam logic [1:0] ADDR_Z      = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [2:0] CH_X  = 3'b101;
  localparam logic [2:0] CH_Y  = 3'b001;
  localparam logic [2:0] CH_Z1 = 3'b011;
  localparam logic [2:0] CH_Z2 = 3'b100;

  localparam int unsigned CTRL_PEN_DOWN_BIT = 0;
  localparam int unsigned FIELD_LO_POS      = 0;
  localparam int unsigned FIELD_HI_POS      = 16;
  localparam int unsigned STATUS_CMD_POS    = 0;
  localparam int unsigned STATUS_CNT_POS    = 8;

  localparam int unsigned CMD_BITS     = 8;
  localparam int unsigned CMD_A_MSB    = 6;
  localparam int unsigned CMD_A_LSB    = 4;
  localparam int unsigned CMD_MODE_BIT = 3;
  localparam int unsigned CMD_PD0_BIT  = 0;

endpackage

// File: rtl/lt24_touch_emu_sync.sv
// Two-flop synchroniser for an asynchronous pin with registered
// rise/fall pulses aligned to the synchronised level.
module lt24_touch_emu_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    rise_d = meta_q & ~sync_q;
    fall_d = ~meta_q & sync_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/lt24_touch_emulator.sv
// LT24 touch controller (XPT2046-style) emulator: Avalon-MM register file feeding
// an SPI slave and pen IRQ. Optional macro LT24_TOUCH_EMU_PENIRQ_MASK_EN masks penirq during conversions.
module lt24_touch_emulator
  import lt24_touch_emu_pkg::*;
#(
  parameter int unsigned ADC_BITS = 12,
  parameter int unsigned CNT_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        spi_cs_n,
  input  logic        spi_dclk,
  input  logic        spi_din,
  output logic        spi_dout,
  output logic        spi_busy,
  output logic        pen_irq_n
);

  localparam int unsigned BC_W = $clog2(ADC_BITS + 1);

  logic cs_n_s, dclk_s, din_s, dclk_rise, dclk_fall;
  logic [1:0] cs_edges_unused, din_edges_unused;
  logic dclk_level_unused, unused_wd;

  lt24_touch_emu_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .async_in(spi_cs_n),
    .level(cs_n_s), .rise(cs_edges_unused[1]), .fall(cs_edges_unused[0]));
  lt24_touch_emu_sync #(.RST_VAL(1'b0)) u_sync_dclk (
    .clk(clk), .reset_n(reset_n), .async_in(spi_dclk),
    .level(dclk_s), .rise(dclk_rise), .fall(dclk_fall));
  lt24_touch_emu_sync #(.RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .reset_n(reset_n), .async_in(spi_din),
    .level(din_s), .rise(din_edges_unused[1]), .fall(din_edges_unused[0]));

  assign dclk_level_unused = dclk_s;
  assign unused_wd         = ^writedata;

  emu_state_e          state_q, state_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ADC_BITS-1:0] shift_q, shift_d;
  logic [ADC_BITS-1:0] x_q, x_d, y_q, y_d, z1_q, z1_d, z2_q, z2_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                pen_down_q, pen_down_d;
  logic                dout_q, dout_d, busy_q, busy_d, pen_irq_n_q, pen_irq_n_d;
  logic [31:0]         readdata_q, readdata_d;

  logic                wr;
  logic [CMD_BITS-1:0] cmd_byte;
  logic [ADC_BITS-1:0] field, result;
  logic [BC_W-1:0]     nbits;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    x_d        = x_q;
    y_d        = y_q;
    z1_d       = z1_q;
    z2_d       = z2_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    pen_down_d = pen_down_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    readdata_d = '0;

    wr       = chipselect & ~write_n;
    cmd_byte = {shift_q[CMD_BITS-2:0], din_s};
    nbits    = cmd_q[CMD_MODE_BIT] ? BC_W'(8) : BC_W'(ADC_BITS);

    case (cmd_byte[CMD_A_MSB:CMD_A_LSB])
      CH_X:    field = x_q;
      CH_Y:    field = y_q;
      CH_Z1:   field = z1_q;
      CH_Z2:   field = z2_q;
      default: field = '0;
    endcase
    // 8-bit mode keeps the top byte left-aligned so the MSB-first shift is shared
    result = field;
    if (cmd_byte[CMD_MODE_BIT]) result[ADC_BITS-9:0] = '0;

    if (wr) begin
      case (address)
        ADDR_CTRL: pen_down_d = writedata[CTRL_PEN_DOWN_BIT];
        ADDR_XY: begin
          x_d = writedata[FIELD_LO_POS +: ADC_BITS];
          y_d = writedata[FIELD_HI_POS +: ADC_BITS];
        end
        ADDR_Z: begin
          z1_d = writedata[FIELD_LO_POS +: ADC_BITS];
          z2_d = writedata[FIELD_HI_POS +: ADC_BITS];
        end
        default: ;
      endcase
    end

    if (cs_n_s) begin
      state_d = ST_IDLE;
      dout_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT: if (dclk_rise && din_s) begin
          state_d   = ST_CMD;
          bit_cnt_d = BC_W'(1);
          shift_d   = ADC_BITS'(1);
        end
        ST_CMD: if (dclk_rise) begin
          if (bit_cnt_q == BC_W'(CMD_BITS - 1)) begin
            cmd_d   = cmd_byte;
            shift_d = result;
            state_d = ST_CONV;
          end else begin
            shift_d   = {shift_q[ADC_BITS-2:0], din_s};
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
        // busy_q doubles as the sub-step marker between the two conversion falls
        ST_CONV: if (dclk_fall) begin
          if (!busy_q) begin
            busy_d = 1'b1;
          end else begin
            busy_d    = 1'b0;
            dout_d    = shift_q[ADC_BITS-1];
            shift_d   = {shift_q[ADC_BITS-2:0], 1'b0};
            bit_cnt_d = BC_W'(1);
            state_d   = ST_DATA;
          end
        end
        ST_DATA: if (dclk_fall) begin
          if (bit_cnt_q == nbits) begin
            dout_d  = 1'b0;
            cnt_d   = cnt_q + CNT_BITS'(1);
            state_d = ST_HUNT;
          end else begin
            dout_d    = shift_q[ADC_BITS-1];
            shift_d   = {shift_q[ADC_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (wr && address == ADDR_STATUS) cnt_d = '0;

    pen_irq_n_d = ~(pen_down_d & ~cmd_d[CMD_PD0_BIT]);
`ifdef LT24_TOUCH_EMU_PENIRQ_MASK_EN
    if (state_d inside {ST_CMD, ST_CONV, ST_DATA}) pen_irq_n_d = 1'b1;
`else
`endif

    case (address)
      ADDR_CTRL: readdata_d[CTRL_PEN_DOWN_BIT] = pen_down_q;
      ADDR_XY: begin
        readdata_d[FIELD_LO_POS +: ADC_BITS] = x_q;
        readdata_d[FIELD_HI_POS +: ADC_BITS] = y_q;
      end
      ADDR_Z: begin
        readdata_d[FIELD_LO_POS +: ADC_BITS] = z1_q;
        readdata_d[FIELD_HI_POS +: ADC_BITS] = z2_q;
      end
      default: begin
        readdata_d[STATUS_CMD_POS +: CMD_BITS] = cmd_q;
        readdata_d[STATUS_CNT_POS +: CNT_BITS] = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z1_q        <= '0;
      z2_q        <= '0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      pen_down_q  <= 1'b0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      pen_irq_n_q <= 1'b1;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z1_q        <= z1_d;
      z2_q        <= z2_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      pen_down_q  <= pen_down_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      pen_irq_n_q <= pen_irq_n_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata  = readdata_q;
  assign spi_dout  = dout_q;
  assign spi_busy  = busy_q;
  assign pen_irq_n = pen_irq_n_q;

endmodule

// File: tb/tb_lt24_touch_emulator.sv
// Directed bench for lt24_touch_emulator: register access, SPI conversion
// frames in 12/8-bit mode, abort, counter wrap/clear and mid-frame reset.
module tb_lt24_touch_emulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        spi_cs_n = 1'b1;
  logic        spi_dclk = 1'b0;
  logic        spi_din = 1'b0;
  logic        spi_dout, spi_busy, pen_irq_n;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] dsamp, bsamp, rd;

  lt24_touch_emulator #(.ADC_BITS(12), .CNT_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .spi_cs_n(spi_cs_n), .spi_dclk(spi_dclk), .spi_din(spi_din),
    .spi_dout(spi_dout), .spi_busy(spi_busy), .pen_irq_n(pen_irq_n));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a;
    tick(1);
    d = readdata;
  endtask

  // One SPI frame of ndclk clocks; dout/busy sampled just before each rising edge.
  task automatic xfer(input logic [7:0] cmd, input int ndclk, input int half,
                      input bit stop_hi, input bit clr_end);
    for (int k = 1; k <= ndclk; k++) begin
      spi_din = (k <= 8) ? cmd[8-k] : 1'b0;
      tick(half);
      dsamp[k] = spi_dout;
      bsamp[k] = spi_busy;
      spi_dclk = 1'b1;
      tick(half);
      if (stop_hi && k == ndclk) return;
      spi_dclk = 1'b0;
      if (clr_end && k == ndclk) begin
        tick(2);
        address = 2'd3; chipselect = 1'b1; write_n = 1'b0;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1;
      end
    end
    spi_din = 1'b0;
  endtask

  function automatic logic [31:0] rx_bits(input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], dsamp[10+i]};
    return r;
  endfunction

  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(2);
    for (int a = 0; a < 4; a++) begin
      reg_rd(a[1:0], rd);
      check("reset_reg", rd, 32'h0);
    end
    check("reset_pen_irq_n", {31'b0, pen_irq_n}, 32'h1);
    check("reset_dout", {31'b0, spi_dout}, 32'h0);
    check("reset_busy", {31'b0, spi_busy}, 32'h0);

    reg_wr(2'd0, 32'h1);
    check("ctrl1_pen_irq_n", {31'b0, pen_irq_n}, 32'h0);
    reg_rd(2'd0, rd);
    check("ctrl_read", rd, 32'h1);
    reg_wr(2'd0, 32'h0);
    check("ctrl0_pen_irq_n", {31'b0, pen_irq_n}, 32'h1);

    reg_wr(2'd1, 32'hFABC_F123);
    reg_rd(2'd1, rd);
    check("xy_read", rd, 32'h0ABC_0123);
    spi_cs_n = 1'b0;
    tick(4);
    xfer(8'hD0, 24, 8, 1'b0, 1'b0);
    check("x12_busy_before", bsamp[8], 32'h0);
    check("x12_busy_pulse", bsamp[9], 32'h1);
    check("x12_busy_after", bsamp[10], 32'h0);
    check("x12_data", rx_bits(12), 32'h123);
    check("x12_dout_end", dsamp[22], 32'h0);
    reg_rd(2'd3, rd);
    check("status_d0", rd, 32'h0000_01D0);

    reg_wr(2'd2, 32'h0000_0F5A);
    reg_rd(2'd2, rd);
    check("z_read", rd, 32'h0000_0F5A);
    xfer(8'hB8, 20, 8, 1'b0, 1'b0);
    check("z1_8bit_data", rx_bits(8), 32'hF5);
    check("z1_8bit_dout_end", dsamp[18], 32'h0);
    reg_rd(2'd3, rd);
    check("status_b8", rd, 32'h0000_02B8);

    reg_wr(2'd0, 32'h1);
    check("pen_down_irq", {31'b0, pen_irq_n}, 32'h0);
    xfer(8'hD1, 24, 8, 1'b0, 1'b0);
    tick(2);
    check("pd0_irq_disabled", {31'b0, pen_irq_n}, 32'h1);
    check("d1_data", rx_bits(12), 32'h123);
    reg_rd(2'd3, rd);
    check("status_d1", rd, 32'h0000_03D1);

    xfer(8'h90, 14, 8, 1'b1, 1'b0);
    check("abort_first5", rx_bits(5), 32'h15);
    spi_cs_n = 1'b1;
    tick(4);
    check("abort_dout", {31'b0, spi_dout}, 32'h0);
    check("abort_busy", {31'b0, spi_busy}, 32'h0);
    spi_dclk = 1'b0;
    tick(4);
    reg_rd(2'd3, rd);
    check("abort_status", rd, 32'h0000_0390);
    spi_cs_n = 1'b0;
    tick(4);
    xfer(8'h90, 24, 8, 1'b0, 1'b0);
    tick(2);
    check("y12_data", rx_bits(12), 32'hABC);
    check("pd0_irq_reenabled", {31'b0, pen_irq_n}, 32'h0);
    reg_rd(2'd3, rd);
    check("status_after_abort", rd, 32'h0000_0490);

    reg_wr(2'd3, 32'h0);
    reg_rd(2'd3, rd);
    check("status_clear", rd, 32'h0000_0090);
    for (int f = 0; f < 255; f++) xfer(8'hB8, 17, 4, 1'b0, 1'b0);
    tick(4);
    reg_rd(2'd3, rd);
    check("cnt_255", rd, 32'h0000_FFB8);
    xfer(8'hB8, 17, 4, 1'b0, 1'b0);
    tick(4);
    reg_rd(2'd3, rd);
    check("cnt_wrap", rd, 32'h0000_00B8);
    check("fast_data", rx_bits(8), 32'hF5);
    xfer(8'hB8, 17, 4, 1'b0, 1'b1);
    tick(4);
    reg_rd(2'd3, rd);
    check("clear_wins", rd, 32'h0000_00B8);

    xfer(8'hD0, 5, 8, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick(2);
    check("midreset_dout", {31'b0, spi_dout}, 32'h0);
    check("midreset_busy", {31'b0, spi_busy}, 32'h0);
    check("midreset_irq", {31'b0, pen_irq_n}, 32'h1);
    check("midreset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    tick(4);
    reg_wr(2'd1, 32'h0000_05A5);
    xfer(8'hD0, 24, 8, 1'b0, 1'b0);
    check("post_reset_data", rx_bits(12), 32'h5A5);
    reg_rd(2'd3, rd);
    check("post_reset_status", rd, 32'h0000_01D0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
